// File: rtl/chimp_pkg.sv
// Shared types and helpers for the chimp-test round sequencer.
package chimp_pkg;

    localparam int GRID      = 3;
    localparam int NUM_CELLS = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_SHOW,
        ST_INPUT,
        ST_LOSE,
        ST_WIN
    } state_t;

    // Flat cell index of a grid position: row*3+col.
    function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
        return ({2'b00, row} * 4'(GRID)) + {2'b00, col};
    endfunction

endpackage

// File: rtl/chimp_lfsr.sv
// 8-bit maximal-length Fibonacci LFSR (taps 8,6,5,4) exposing its low OUT_W bits.
module chimp_lfsr #(
    parameter logic [7:0] SEED  = 8'hA5,
    parameter int         OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [OUT_W-1:0] rnd
);

    logic [7:0] state;

    // Shift left, feeding back the XOR of taps 8,6,5,4.
    // NOTE: sequential state is only ever assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else if (en) begin
            state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
        end
    end

    assign rnd = state[OUT_W-1:0];

endmodule

// File: rtl/chimp_game_ctrl.sv
// Round sequencer for the chimp-test memory game: places 1..level on random
// cells, shows them, then checks the player selects them in ascending order.
module chimp_game_ctrl
    import chimp_pkg::*;
#(
    parameter int          START_LEVEL = 4,
    parameter int          MAX_LEVEL   = 9,
    parameter logic [31:0] SHOW_CYCLES = 32'd100_000_000,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       select,
    input  logic [1:0] row,
    input  logic [1:0] col,
    input  logic [3:0] disp_cell,
    output logic [3:0] disp_num,
    output logic [8:0] occupied,
    output logic       show,
    output logic [3:0] level,
    output logic [3:0] next_num,
    output logic       round_win,
    output logic       game_over,
    output logic       game_won
);

    localparam logic [3:0]  START_LV  = 4'(START_LEVEL);
    localparam logic [3:0]  MAX_LV    = 4'(MAX_LEVEL);
    localparam logic [31:0] SHOW_LAST = SHOW_CYCLES - 32'd1;

    state_t      state;
    logic [3:0]  num [NUM_CELLS];
    logic [3:0]  place;
    logic [31:0] show_timer;

    logic [3:0]  cand;
    logic [3:0]  cand_num;
    logic        cand_ok;
    logic [3:0]  sel_cell;
    logic [3:0]  sel_num;
    logic        sel_valid;
    logic        show_timeout;

    chimp_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (4)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .rnd (cand)
    );

    assign cand_ok      = (cand < 4'(NUM_CELLS));
    assign sel_cell     = cell_index(row, col);
    assign sel_valid    = select && (row != 2'd3) && (col != 2'd3);
    assign show_timeout = (SHOW_CYCLES != 32'd0) && (show_timer == SHOW_LAST);

    // Read ports into the number array: GEN candidate, player select, display.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        cand_num = 4'd0;
        sel_num  = 4'd0;
        disp_num = 4'd0;
        occupied = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (cand == 4'(i))      cand_num = num[i];
            if (sel_cell == 4'(i))  sel_num  = num[i];
            if (disp_cell == 4'(i)) disp_num = num[i];
            occupied[i] = (num[i] != 4'd0);
        end
    end

    // Game FSM with all flags registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            // NOTE: the number array is reset too, so a mid-round reset leaves no stale numbers behind.
            for (int i = 0; i < NUM_CELLS; i++) num[i] <= 4'd0;
            level      <= START_LV;
            next_num   <= 4'd1;
            place      <= 4'd1;
            show_timer <= '0;
            show       <= 1'b0;
            round_win  <= 1'b0;
            game_over  <= 1'b0;
            game_won   <= 1'b0;
        end else begin
            round_win <= 1'b0;
            case (state)
                ST_IDLE, ST_LOSE, ST_WIN: begin
                    if (start) begin
                        for (int i = 0; i < NUM_CELLS; i++) num[i] <= 4'd0;
                        level     <= START_LV;
                        next_num  <= 4'd1;
                        place     <= 4'd1;
                        show      <= 1'b0;
                        game_over <= 1'b0;
                        game_won  <= 1'b0;
                        state     <= ST_GEN;
                    end
                end

                ST_GEN: begin
                    if (cand_ok && (cand_num == 4'd0)) begin
                        for (int i = 0; i < NUM_CELLS; i++) begin
                            if (cand == 4'(i)) num[i] <= place;
                        end
                        place <= place + 4'd1;
                        if (place == level) begin
                            next_num   <= 4'd1;
                            show_timer <= '0;
                            show       <= 1'b1;
                            state      <= ST_SHOW;
                        end
                    end
                end

                ST_SHOW, ST_INPUT: begin
                    if (state == ST_SHOW) show_timer <= show_timer + 32'd1;
                    if (sel_valid && (sel_num != 4'd0)) begin
                        if (sel_num == next_num) begin
                            for (int i = 0; i < NUM_CELLS; i++) begin
                                if (sel_cell == 4'(i)) num[i] <= 4'd0;
                            end
                            show <= 1'b0;
                            if (next_num == level) begin
                                // Round cleared; the array is already empty here.
                                round_win <= 1'b1;
                                next_num  <= 4'd1;
                                if (level == MAX_LV) begin
                                    game_won <= 1'b1;
                                    state    <= ST_WIN;
                                end else begin
                                    level <= level + 4'd1;
                                    place <= 4'd1;
                                    state <= ST_GEN;
                                end
                            end else begin
                                next_num <= next_num + 4'd1;
                                state    <= ST_INPUT;
                            end
                        end else begin
                            show      <= 1'b0;
                            game_over <= 1'b1;
                            state     <= ST_LOSE;
                        end
                    end else if ((state == ST_SHOW) && show_timeout) begin
                        show  <= 1'b0;
                        state <= ST_INPUT;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chimp_game_ctrl.sv
// Self-checking bench for chimp_game_ctrl: scoreboard of select responses
// against a board-level model of the game, plus GEN/SHOW timing checks.
module tb_chimp_game_ctrl;

    localparam logic [7:0] SEED = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, use_b;
    logic       start, select;
    logic [1:0] row, col;
    logic [3:0] disp_cell;

    logic [3:0] a_disp, b_disp, a_level, b_level, a_next, b_next;
    logic [8:0] a_occ, b_occ;
    logic       a_show, b_show, a_rw, b_rw, a_over, b_over, a_won, b_won;

    logic [3:0] o_disp, o_level, o_next;
    logic [8:0] o_occ;
    logic       o_show, o_rw, o_over, o_won;

    always #5 clk = ~clk;

    chimp_game_ctrl #(
        .START_LEVEL (4), .MAX_LEVEL (9), .SHOW_CYCLES (32'd100_000_000), .LFSR_SEED (SEED)
    ) u_a (
        .clk (clk), .rst (rst_a), .start (start & ~use_b), .select (select & ~use_b),
        .row (row), .col (col), .disp_cell (disp_cell), .disp_num (a_disp),
        .occupied (a_occ), .show (a_show), .level (a_level), .next_num (a_next),
        .round_win (a_rw), .game_over (a_over), .game_won (a_won)
    );

    chimp_game_ctrl #(
        .START_LEVEL (9), .MAX_LEVEL (9), .SHOW_CYCLES (32'd20), .LFSR_SEED (SEED)
    ) u_b (
        .clk (clk), .rst (rst_b), .start (start & use_b), .select (select & use_b),
        .row (row), .col (col), .disp_cell (disp_cell), .disp_num (b_disp),
        .occupied (b_occ), .show (b_show), .level (b_level), .next_num (b_next),
        .round_win (b_rw), .game_over (b_over), .game_won (b_won)
    );

    assign o_disp  = use_b ? b_disp  : a_disp;
    assign o_level = use_b ? b_level : a_level;
    assign o_next  = use_b ? b_next  : a_next;
    assign o_occ   = use_b ? b_occ   : a_occ;
    assign o_show  = use_b ? b_show  : a_show;
    assign o_rw    = use_b ? b_rw    : a_rw;
    assign o_over  = use_b ? b_over  : a_over;
    assign o_won   = use_b ? b_won   : a_won;

    // Clock edges since each DUT left reset = number of LFSR steps taken.
    int cyc_a, cyc_b;
    always @(posedge clk or posedge rst_a) if (rst_a) cyc_a <= 0; else cyc_a <= cyc_a + 1;
    always @(posedge clk or posedge rst_b) if (rst_b) cyc_b <= 0; else cyc_b <= cyc_b + 1;

    // ---------------- reference model ----------------
    int  board [9];
    int  m_level, m_next, m_start_level, m_max;
    bit  m_show, m_over, m_won, gen_pending;

    typedef struct {
        bit       show, over, won, rw;
        int       next, level;
        logic [8:0] occ;
    } exp_t;
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [8:0] model_occ();
        logic [8:0] o = '0;
        for (int i = 0; i < 9; i++) o[i] = (board[i] != 0);
        return o;
    endfunction

    // Polynomial x^8+x^6+x^5+x^4+1, advanced n times from the seed.
    function automatic logic [7:0] lfsr_after(input int n);
        logic [7:0] x = SEED;
        for (int k = 0; k < n; k++) x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
        return x;
    endfunction

    // Place 1..m_level from the random stream and check GEN length and result.
    task automatic run_gen(input int cyc0);
        logic [7:0] x;
        int p, len, c, n;
        bit seen;
        x = lfsr_after(cyc0);
        p = 1;
        len = 0;
        while (p <= m_level && len < 10000) begin
            c = int'(x[3:0]);
            len++;
            if (c < 9 && board[c] == 0) begin
                board[c] = p;
                p++;
            end
            x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
        end
        seen = 0;
        n = -1;
        for (int k = 1; k <= len + 8; k++) begin
            @(posedge clk); #2;
            if (k == 1) check("round_win_width", o_rw, 0);
            if (o_show) begin n = k; seen = 1; break; end
        end
        check("gen_cycles", n, len);
        m_show = 1;
        m_next = 1;
        check("show_after_gen", o_show, 1);
        check("occupied_after_gen", o_occ, model_occ());
        check("next_num_after_gen", o_next, 1);
        check("level_after_gen", o_level, m_level);
    endtask

    task automatic check_board();
        for (int i = 0; i < 9; i++) begin
            disp_cell = 4'(i); #1;
            check($sformatf("disp_num[%0d]", i), o_disp, board[i]);
        end
        disp_cell = 4'd12; #1;
        check("disp_num[12]", o_disp, 0);
        disp_cell = 4'd15; #1;
        check("disp_num[15]", o_disp, 0);
        disp_cell = 4'd0;
        @(negedge clk);
    endtask

    task automatic do_select(input int r, input int c);
        exp_t e;
        int idx, v;
        bit rw;
        @(negedge clk);
        rw = 0;
        if (!m_over && !m_won && r < 3 && c < 3) begin
            idx = r * 3 + c;
            v = board[idx];
            if (v != 0) begin
                if (v == m_next) begin
                    board[idx] = 0;
                    m_show = 0;
                    if (m_next == m_level) begin
                        rw = 1;
                        m_next = 1;
                        if (m_level == m_max) m_won = 1;
                        else begin
                            m_level++;
                            gen_pending = 1;
                        end
                    end else begin
                        m_next++;
                    end
                end else begin
                    m_over = 1;
                    m_show = 0;
                end
            end
        end
        e.show = m_show; e.over = m_over; e.won = m_won; e.rw = rw;
        e.next = m_next; e.level = m_level; e.occ = model_occ();
        exp_q.push_back(e);
        row = 2'(r); col = 2'(c); select = 1'b1;
        @(posedge clk); #2;
        select = 1'b0;
        if (gen_pending) begin
            gen_pending = 0;
            run_gen(use_b ? cyc_b : cyc_a);
        end
    endtask

    task automatic select_num(input int k);
        int idx = 0;
        for (int i = 0; i < 9; i++) if (board[i] == k) idx = i;
        do_select(idx / 3, idx % 3);
    endtask

    task automatic select_empty();
        int idx = 0;
        for (int i = 8; i >= 0; i--) if (board[i] == 0) idx = i;
        do_select(idx / 3, idx % 3);
    endtask

    task automatic do_start();
        int cyc0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        cyc0 = use_b ? cyc_b : cyc_a;
        for (int i = 0; i < 9; i++) board[i] = 0;
        m_level = m_start_level;
        m_next = 1;
        m_over = 0;
        m_won = 0;
        m_show = 0;
        run_gen(cyc0);
    endtask

    // Monitor: whenever a select was presented, pop and compare the response.
    initial begin
        bit s;
        exp_t e;
        forever begin
            @(posedge clk);
            s = select;
            #1;
            if (s) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_has_entry", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("sel_show",      o_show,  e.show);
                    check("sel_game_over", o_over,  e.over);
                    check("sel_game_won",  o_won,   e.won);
                    check("sel_round_win", o_rw,    e.rw);
                    check("sel_next_num",  o_next,  e.next);
                    check("sel_level",     o_level, e.level);
                    check("sel_occupied",  o_occ,   e.occ);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        use_b = 0; start = 0; select = 0; row = 0; col = 0; disp_cell = 0;
        gen_pending = 0;
        rst_a = 1; rst_b = 1;
        repeat (3) @(negedge clk);
        rst_a = 0; rst_b = 0;
        repeat (10) @(negedge clk);

        // Reset state
        check("rst_occupied", a_occ, 0);
        check("rst_level", a_level, 4);
        check("rst_next_num", a_next, 1);
        check("rst_show", a_show, 0);
        check("rst_round_win", a_rw, 0);
        check("rst_game_over", a_over, 0);
        check("rst_game_won", a_won, 0);
        check("rst_b_level", b_level, 9);
        check("rst_disp", a_disp, 0);

        // Round 1 of DUT A, cleared in order
        m_start_level = 4; m_max = 9;
        do_start();
        check_board();
        for (int k = 1; k <= 4; k++) select_num(k);
        check_board();

        // Round 2: correct 1 then wrong 3 -> LOSE, select afterwards ignored
        select_num(1);
        select_num(3);
        select_num(2);

        // Restart from LOSE
        do_start();
        check("restart_level", o_level, 4);
        select_empty();
        do_select(3, 0);
        do_select(1, 3);
        select_num(1);
        select_empty();

        // start in INPUT is ignored
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("start_ignored_level", o_level, m_level);
        check("start_ignored_next", o_next, m_next);
        check("start_ignored_occ", o_occ, model_occ());
        for (int k = 2; k <= 4; k++) select_num(k);

        // DUT B: single round at level 9, SHOW timeout of 20 cycles
        @(negedge clk);
        use_b = 1;
        m_start_level = 9; m_max = 9;
        do_start();
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #2;
            if (!o_show) begin n = k; break; end
        end
        check("show_timeout_cycles", n, 20);
        m_show = 0;
        check_board();
        for (int k = 1; k <= 9; k++) select_num(k);
        @(posedge clk); #2;
        check("win_round_win_width", o_rw, 0);
        check("win_held", o_won, 1);
        do_select(0, 0);

        // Restart from WIN, then reset mid-INPUT
        do_start();
        for (int k = 1; k <= 3; k++) select_num(k);
        #1;
        rst_b = 1'b1;
        #1;
        check("midrst_occupied", o_occ, 0);
        check("midrst_level", o_level, 9);
        check("midrst_next_num", o_next, 1);
        check("midrst_show", o_show, 0);
        check("midrst_round_win", o_rw, 0);
        check("midrst_game_over", o_over, 0);
        check("midrst_game_won", o_won, 0);
        @(negedge clk);
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check("postrst_occupied", o_occ, 0);
        check("postrst_show", o_show, 0);
        check("postrst_level", o_level, 9);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
